// File: rtl/fft_pkg.sv
// Shared constants for the transform blocks.
//   NPT/LOG2_NPT : default transform length, W/Q : sign-magnitude width
//   and fractional bits, ONE : +1.0 in that format, S_* : idft_synth
//   state encoding, cos_q16() : elaboration-time cosine table generator.
package fft_pkg;
    localparam int NPT      = 512;
    localparam int LOG2_NPT = 9;
    localparam int W        = 80;
    localparam int Q        = 16;
    localparam logic [W-1:0] ONE = W'(1) << Q;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_CLR_T = 4'd1;
    localparam logic [3:0] S_RD    = 4'd2;
    localparam logic [3:0] S_WT    = 4'd3;
    localparam logic [3:0] S_MUL   = 4'd4;
    localparam logic [3:0] S_SUM   = 4'd5;
    localparam logic [3:0] S_SCL   = 4'd6;
    localparam logic [3:0] S_WR    = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;

    // cos(2*pi*p/npt) as 32-bit sign-magnitude Q16. The angle is folded
    // into [0, pi/2] and a Taylor series is summed in Q28 integers, so the
    // table is built with constant integer arithmetic only.
    function automatic logic [31:0] cos_q16(input int p, input int npt);
        longint a, a2, term, sum;
        int     p2, p3;
        logic   neg;
        logic [30:0] mag;
        p2  = (p > npt / 2) ? npt - p : p;
        neg = 1'b0;
        p3  = p2;
        if (p2 > npt / 4) begin
            neg = 1'b1;
            p3  = npt / 2 - p2;
        end
        a    = (64'sd2 * 64'sd843314857 * longint'(p3)) / longint'(npt);
        a2   = (a * a) >>> 28;
        term = 64'sd1 <<< 28;
        sum  = term;
        for (int n = 1; n <= 7; n++) begin
            term = -(((term * a2) >>> 28) / longint'((2 * n - 1) * (2 * n)));
            sum  = sum + term;
        end
        mag = 31'((sum + 64'sd2048) >>> 12);
        if (4 * p3 == npt) mag = '0;  // exact zero at +-pi/2
        return {neg & (mag != '0), mag};
    endfunction
endpackage

// File: rtl/idft_twiddle_rom.sv
// Dual-read cosine ROM, one-cycle registered output.
//   clk              : clock
//   index_c, index_s : read indices (sin port is fed a phase-shifted index)
//   cos_q, sin_q     : 32-bit sign-magnitude Q16 table values
module idft_twiddle_rom #(
    parameter int NPT      = 512,
    parameter int LOG2_NPT = 9
) (
    input  logic                clk,
    input  logic [LOG2_NPT-1:0] index_c,
    input  logic [LOG2_NPT-1:0] index_s,
    output logic [31:0]         cos_q,
    output logic [31:0]         sin_q
);
    logic [NPT-1:0][31:0] tbl;

    for (genvar p = 0; p < NPT; p++) begin : g_tbl
        localparam logic [31:0] V = fft_pkg::cos_q16(p, NPT);
        assign tbl[p] = V;
    end

    always_ff @(posedge clk) begin
        cos_q <= tbl[index_c];
        sin_q <= tbl[index_s];
    end
endmodule

// File: rtl/idft_synth.sv
// Inverse DFT engine: x[t] = (1/NPT) * sum_k X[k] * e^(+j*2*pi*k*t/NPT).
//   clk, rst        : clock, synchronous active-high reset
//   startifft       : start request, honoured in IDLE only
//   addr_in_*       : bin read address (RAM data returns in MUL)
//   in_*_data       : bin read data, sign-magnitude
//   addr_out_*      : sample write address
//   write_ifft_*    : sample write data, qualified by we_out
//   we_out          : one-cycle write strobe for both output RAMs
//   doneifft        : one-cycle completion pulse
module idft_synth #(
    parameter int NPT      = fft_pkg::NPT,
    parameter int LOG2_NPT = fft_pkg::LOG2_NPT,
    parameter int AW       = 10,
    parameter int W        = fft_pkg::W,
    parameter int Q        = fft_pkg::Q
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          startifft,
    output logic [AW-1:0] addr_in_real,
    output logic [AW-1:0] addr_in_imag,
    input  logic [W-1:0]  in_real_data,
    input  logic [W-1:0]  in_imag_data,
    output logic [AW-1:0] addr_out_real,
    output logic [AW-1:0] addr_out_imag,
    output logic [W-1:0]  write_ifft_real,
    output logic [W-1:0]  write_ifft_imag,
    output logic          we_out,
    output logic          doneifft
);
    import fft_pkg::*;

    localparam int M = W - 1;  // magnitude width
    localparam logic [LOG2_NPT-1:0] LAST    = LOG2_NPT'(NPT - 1);
    localparam logic [LOG2_NPT-1:0] QUARTER = LOG2_NPT'(NPT / 4);

    // Sign-magnitude multiply, Q-aligned and truncated; zero is always +0.
    function automatic logic [W-1:0] qmult(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*M-1:0] p;
        logic [M-1:0]   m;
        p = {{M{1'b0}}, a[M-1:0]} * {{M{1'b0}}, b[M-1:0]};
        m = p[Q +: M];
        return {(a[W-1] ^ b[W-1]) & (m != '0), m};
    endfunction

    // Sign-magnitude add; zero is always +0.
    function automatic logic [W-1:0] qadd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [M-1:0] m;
        logic         s;
        if (a[W-1] == b[W-1]) begin
            m = a[M-1:0] + b[M-1:0];
            s = a[W-1];
        end else if (a[M-1:0] >= b[M-1:0]) begin
            m = a[M-1:0] - b[M-1:0];
            s = a[W-1];
        end else begin
            m = b[M-1:0] - a[M-1:0];
            s = b[W-1];
        end
        return {s & (m != '0), m};
    endfunction

    function automatic logic [W-1:0] qneg(input logic [W-1:0] a);
        return {~a[W-1], a[M-1:0]};
    endfunction

    // Divide by NPT: truncate the magnitude, drop the sign of a zero result.
    function automatic logic [W-1:0] qscale(input logic [W-1:0] a);
        logic [M-1:0] m;
        m = a[M-1:0] >> LOG2_NPT;
        return {a[W-1] & (m != '0), m};
    endfunction

    function automatic logic [W-1:0] widen(input logic [31:0] c);
        return {c[31], {(W-32){1'b0}}, c[30:0]};
    endfunction

    logic [3:0]          state_q, state_d;
    logic [LOG2_NPT-1:0] t_q, k_q, phase_q, idx_c_q, idx_s_q;
    logic [W-1:0]        sumre_q, sumim_q;
    logic [W-1:0]        p_rc_q, p_is_q, p_rs_q, p_ic_q;
    logic [AW-1:0]       addr_in_q, addr_out_q;
    logic [W-1:0]        wr_re_q, wr_im_q;
    logic                we_q, done_q;
    logic [31:0]         cos_q, sin_q;
    logic [W-1:0]        cos_w, sin_w;

    idft_twiddle_rom #(.NPT(NPT), .LOG2_NPT(LOG2_NPT)) u_rom (
        .clk     (clk),
        .index_c (idx_c_q),
        .index_s (idx_s_q),
        .cos_q   (cos_q),
        .sin_q   (sin_q)
    );

    assign cos_w = widen(cos_q);
    assign sin_w = widen(sin_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (startifft) state_d = S_CLR_T;
            S_CLR_T: state_d = S_RD;
            S_RD:    state_d = S_WT;
            S_WT:    state_d = S_MUL;
            S_MUL:   state_d = S_SUM;
            S_SUM:   state_d = (k_q == LAST) ? S_SCL : S_RD;
            S_SCL:   state_d = S_WR;
            S_WR:    state_d = (t_q == LAST) ? S_DONE : S_CLR_T;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            t_q        <= '0;
            k_q        <= '0;
            phase_q    <= '0;
            idx_c_q    <= '0;
            idx_s_q    <= '0;
            sumre_q    <= '0;
            sumim_q    <= '0;
            p_rc_q     <= '0;
            p_is_q     <= '0;
            p_rs_q     <= '0;
            p_ic_q     <= '0;
            addr_in_q  <= '0;
            addr_out_q <= '0;
            wr_re_q    <= '0;
            wr_im_q    <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_CLR_T: begin
                    sumre_q <= '0;
                    sumim_q <= '0;
                    k_q     <= '0;
                    phase_q <= '0;
                end
                S_RD: begin
                    addr_in_q <= AW'(k_q);
                    idx_c_q   <= phase_q;
                    // sin(x) = cos(x - pi/2); index arithmetic wraps mod NPT
                    idx_s_q   <= phase_q - QUARTER;
                end
                S_MUL: begin
                    p_rc_q <= qmult(in_real_data, cos_w);
                    p_is_q <= qmult(in_imag_data, sin_w);
                    p_rs_q <= qmult(in_real_data, sin_w);
                    p_ic_q <= qmult(in_imag_data, cos_w);
                end
                S_SUM: begin
                    sumre_q <= qadd(sumre_q, qadd(p_rc_q, qneg(p_is_q)));
                    sumim_q <= qadd(sumim_q, qadd(p_rs_q, p_ic_q));
                    // phase tracks (k*t) mod NPT exactly
                    phase_q <= phase_q + t_q;
                    k_q     <= k_q + 1'b1;
                end
                S_SCL: begin
                    sumre_q <= qscale(sumre_q);
                    sumim_q <= qscale(sumim_q);
                end
                S_WR: begin
                    addr_out_q <= AW'(t_q);
                    wr_re_q    <= sumre_q;
                    wr_im_q    <= sumim_q;
                    we_q       <= 1'b1;
                    t_q        <= t_q + 1'b1;  // wraps to 0 after the last sample
                    done_q     <= (t_q == LAST);
                end
                default: ;
            endcase
        end
    end

    assign addr_in_real    = addr_in_q;
    assign addr_in_imag    = addr_in_q;
    assign addr_out_real   = addr_out_q;
    assign addr_out_imag   = addr_out_q;
    assign write_ifft_real = wr_re_q;
    assign write_ifft_imag = wr_im_q;
    assign we_out          = we_q;
    assign doneifft        = done_q;
endmodule

// File: tb/tb_idft_synth.sv
module tb_idft_synth;
    localparam int NPT = 16;
    localparam int LG  = 4;
    localparam int AW  = 10;
    localparam int W   = 80;
    localparam int Q   = 16;
    localparam longint RUN = longint'(NPT * (4 * NPT + 3) + 1);
    localparam real PI = 3.14159265358979323846;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          startifft = 1'b0;
    logic [AW-1:0] air, aii, aor, aoi;
    logic [W-1:0]  ird, iid, wr, wi;
    logic          we, done;

    logic [W-1:0] mem_re [NPT];
    logic [W-1:0] mem_im [NPT];

    typedef struct {
        int          a;
        int          ai;
        logic [W-1:0] re;
        logic [W-1:0] im;
    } wr_t;
    wr_t    wq[$];
    longint done_cyc[$];
    int     n_done = 0;
    longint cyc = 0;
    int     n_chk = 0;
    int     n_pass = 0;

    idft_synth #(.NPT(NPT), .LOG2_NPT(LG), .AW(AW), .W(W), .Q(Q)) dut (
        .clk(clk), .rst(rst), .startifft(startifft),
        .addr_in_real(air), .addr_in_imag(aii),
        .in_real_data(ird), .in_imag_data(iid),
        .addr_out_real(aor), .addr_out_imag(aoi),
        .write_ifft_real(wr), .write_ifft_imag(wi),
        .we_out(we), .doneifft(done)
    );

    always #5 clk = ~clk;

    // bin RAM pair: one registered read stage
    always @(posedge clk) begin
        cyc <= cyc + 1;
        ird <= (air < AW'(NPT)) ? mem_re[air[LG-1:0]] : '0;
        iid <= (aii < AW'(NPT)) ? mem_im[aii[LG-1:0]] : '0;
    end

    always @(negedge clk) begin
        if (we) wq.push_back('{int'(aor), int'(aoi), wr, wi});
        if (done) begin
            n_done <= n_done + 1;
            done_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp, input longint tol = 0);
        longint d;
        d = got - exp;
        if (d < 0) d = -d;
        n_chk++;
        if (d <= tol) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    endtask

    function automatic longint sm2i(input logic [W-1:0] x);
        longint m;
        m = longint'(x[62:0]);
        return x[W-1] ? -m : m;
    endfunction

    function automatic logic [W-1:0] sm(input longint v);
        logic [W-1:0] r;
        r = '0;
        if (v < 0) begin
            r[W-1]  = 1'b1;
            r[62:0] = 63'(-v);
        end else begin
            r[62:0] = 63'(v);
        end
        return r;
    endfunction

    function automatic longint rnd();
        longint m;
        m = longint'($urandom_range(0, 131071));
        return ($urandom_range(0, 1) == 1) ? -m : m;
    endfunction

    function automatic real labs(input longint v);
        return (v < 0) ? -real'(v) : real'(v);
    endfunction

    task automatic clear_bins();
        for (int k = 0; k < NPT; k++) begin
            mem_re[k] = '0;
            mem_im[k] = '0;
        end
    endtask

    // Reference: floating-point inverse DFT of the loaded bins.
    task automatic check_run(input string tag);
        real    xr, xi, th, er, ei, mean;
        longint tol;
        mean = 0.0;
        for (int k = 0; k < NPT; k++)
            mean += (labs(sm2i(mem_re[k])) + labs(sm2i(mem_im[k]))) / 65536.0;
        mean = mean / real'(NPT);
        tol  = 4 + longint'($ceil(1.5 * mean));
        chk({tag, " nwr"}, longint'(wq.size()), longint'(NPT));
        for (int i = 0; i < wq.size() && i < NPT; i++) begin
            chk({tag, " addr"}, longint'(wq[i].a), longint'(i));
            chk({tag, " addr_im"}, longint'(wq[i].ai), longint'(i));
            er = 0.0;
            ei = 0.0;
            for (int k = 0; k < NPT; k++) begin
                xr = real'(sm2i(mem_re[k])) / 65536.0;
                xi = real'(sm2i(mem_im[k])) / 65536.0;
                th = 2.0 * PI * real'((k * i) % NPT) / real'(NPT);
                er += xr * $cos(th) - xi * $sin(th);
                ei += xr * $sin(th) + xi * $cos(th);
            end
            chk({tag, " re"}, sm2i(wq[i].re), longint'(er * 65536.0 / real'(NPT)), tol);
            chk({tag, " im"}, sm2i(wq[i].im), longint'(ei * 65536.0 / real'(NPT)), tol);
            chk({tag, " negzero"},
                longint'((wq[i].re[W-1] && wq[i].re[W-2:0] == '0) ||
                         (wq[i].im[W-1] && wq[i].im[W-2:0] == '0)), 0);
        end
    endtask

    task automatic run(input string tag, input bit pulse);
        int     d0;
        longint st;
        longint i;
        wq.delete();
        d0 = n_done;
        @(negedge clk);
        startifft = 1'b1;
        st = cyc;
        @(negedge clk);
        startifft = 1'b0;
        i = 0;
        while (n_done == d0 && i < RUN + 50) begin
            if (pulse && (i % 150) == 20 && i < RUN - 200) begin
                @(negedge clk) startifft = 1'b1;
                @(negedge clk) startifft = 1'b0;
                i += 2;
            end else begin
                @(posedge clk);
                i++;
            end
        end
        chk({tag, " done"}, longint'(n_done - d0), 1);
        if (n_done > d0) chk({tag, " lat"}, done_cyc[d0] - st, RUN);
        check_run(tag);
    endtask

    initial begin
        int     d0;
        longint st;
        int     i;
        clear_bins();
        repeat (2) @(negedge clk);
        chk("rst we", longint'(we), 0);
        chk("rst done", longint'(done), 0);
        chk("rst ain", longint'(air | aii), 0);
        chk("rst aout", longint'(aor | aoi), 0);
        chk("rst wdata", longint'(|{wr, wi}), 0);
        rst = 1'b0;

        // DC bin: every sample exactly +1.0 real, +0 imag
        mem_re[0] = sm(longint'(NPT) * 65536);
        run("dc", 1'b0);
        for (int t = 0; t < wq.size(); t++) begin
            chk("dc re exact", sm2i(wq[t].re), 65536);
            chk("dc im zero", longint'(wq[t].im != '0), 0);
        end

        // single tone in bin 1
        clear_bins();
        mem_re[1] = sm(longint'(NPT) * 65536);
        run("bin1", 1'b0);
        if (wq.size() == NPT) begin
            chk("bin1 x0 re", sm2i(wq[0].re), 65536, 1);
            chk("bin1 xq im", sm2i(wq[NPT/4].im), 65536, 2);
            chk("bin1 xq re", sm2i(wq[NPT/4].re), 0, 2);
            chk("bin1 xh sign", longint'(wq[NPT/2].re[W-1]), 1);
        end

        // purely imaginary DC
        clear_bins();
        mem_im[0] = sm(longint'(NPT) * 65536);
        run("jdc", 1'b0);
        for (int t = 0; t < wq.size(); t++) begin
            chk("jdc re +0", longint'(wq[t].re != '0), 0);
            chk("jdc im", sm2i(wq[t].im), 65536);
        end

        // negative DC
        clear_bins();
        mem_re[0] = sm(-longint'(NPT) * 65536);
        run("ndc", 1'b0);
        for (int t = 0; t < wq.size(); t++) begin
            chk("ndc sign", longint'(wq[t].re[W-1]), 1);
            chk("ndc mag", longint'(wq[t].re[62:0]), 65536);
        end

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NPT; k++) begin
                mem_re[k] = sm(rnd());
                mem_im[k] = sm(rnd());
            end
            run("rnd", 1'b0);
        end

        // start pulses during a run must be ignored
        run("ctl", 1'b1);

        // abort via reset at cycle 500 of a run
        d0 = n_done;
        @(negedge clk) startifft = 1'b1;
        @(negedge clk) startifft = 1'b0;
        repeat (498) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort we", longint'(we), 0);
        chk("abort done0", longint'(done), 0);
        chk("abort ain", longint'(air | aii), 0);
        chk("abort aout", longint'(aor | aoi), 0);
        chk("abort wdata", longint'(|{wr, wi}), 0);
        wq.delete();
        repeat (int'(RUN) + 20) @(negedge clk);
        chk("abort no done", longint'(n_done - d0), 0);
        chk("abort no wr", longint'(wq.size()), 0);
        run("post rst", 1'b0);

        // held start: back-to-back transforms
        d0 = n_done;
        wq.delete();
        @(negedge clk);
        startifft = 1'b1;
        st = cyc;
        i = 0;
        while (n_done < d0 + 2 && i < 2 * int'(RUN) + 100) begin
            @(negedge clk);
            #1;
            i++;
        end
        startifft = 1'b0;
        chk("hold n", longint'(n_done - d0), 2);
        if (n_done >= d0 + 2) begin
            chk("hold lat", done_cyc[d0] - st, RUN);
            chk("hold gap", done_cyc[d0+1] - done_cyc[d0], RUN + 1);
        end
        repeat (10) @(posedge clk);
        chk("hold stop", longint'(n_done - d0), 2);
        chk("hold nwr", longint'(wq.size()), longint'(2 * NPT));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
